sar_sequencer: RTL and testbench
================================

# sar_sequencer

Round-robin conversion scheduler sharing one generic SAR ADC between NCH requesters. Grants a channel, drives the analogue input-mux select, waits a settling time, and starts a conversion with a toggle on `sar_soc`. It then waits for the `sar_eoc` toggle, captures `sar_code`, and returns the result with its channel tag over a valid/ready handshake. It sits between the digital requesters (regulation loops, monitors) and the SAR block on the `f100m_clk` domain.

## Interface
- NCH, 4, number of requesters (2..8)
- CH_W, 2, channel index width (≥ clog2(NCH))
- NSTEP, 10, SAR code width
- SETTLE, 8, mux settling cycles before start (1..255)
- TIMEOUT, 64, max cycles waiting for end of conversion (2..1023)
- AVG_LOG2, 2, log2 of samples averaged per request (only with SAR_SEQ_AVG_EN)

- f100m_clk  in  1  clock
- rstb  in  1  reset; one clock; reset is synchronous and active-low
- req  in  NCH  per-channel request level; held until matching ack
- ack  out  NCH  one-cycle pulse, bit = served channel, same cycle as res handshake
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ch  out  CH_W  channel of result
- res_code  out  NSTEP  conversion result
- res_err  out  1  error/timeout flag for this result
- busy  out  1  high in any state other than IDLE
- mux_sel  out  CH_W  analogue mux select
- sar_soc  out  1  start of conversion, toggle-encoded
- sar_eoc  in  1  end of conversion, toggle-encoded
- sar_err  in  1  comparator stuck flag, toggle-encoded
- sar_code  in  NSTEP  SAR result, stable when sar_eoc toggles

## Operation
- Reset values: ack=0, res_valid=0, res_ch=0, res_code=0, res_err=0, busy=0, mux_sel=0, sar_soc=0. Round-robin pointer=0. Registered sar_eoc/sar_err copies are loaded with the current inputs, so no false edge is seen.
- States:
  - IDLE: if any req is set, grant the first set bit at or above the pointer, wrapping. Set mux_sel to that channel, load the settle counter with SETTLE, go to SETTLE.
  - SETTLE: decrement; at 0, toggle sar_soc, load the timeout counter with TIMEOUT, go to CONVERT.
  - CONVERT:
    - eoc edge (sar_eoc differs from its registered copy): capture sar_code into the accumulator, go to RESULT.
    - err edge: set the error flag, go to RESULT.
    - timeout counter reaches 0: set the error flag, go to RESULT.
    - Precedence: err edge > eoc edge > timeout.
  - RESULT: res_valid=1 with res_ch/res_code/res_err held stable. When res_valid & res_ready: pulse ack[res_ch], drop res_valid, set pointer = res_ch+1 (mod NCH), go to IDLE.
- On error, res_code=0.
- A req deasserted after grant is still served. No abort exists except reset.
- Edge detectors run in every state; edges outside CONVERT are discarded.
- Reset mid-operation returns all state to the reset values next edge. sar_soc returns to 0; if this creates a toggle, the SAR ignores it because both blocks share rstb.

## Timing
- Grant (IDLE exit) to sar_soc toggle: SETTLE+1 cycles.
- eoc edge seen to res_valid: 1 cycle.
- Handshake to next grant: IDLE is held 1 cycle, so back-to-back requests are spaced by ≥1 idle cycle.
- mux_sel changes only on IDLE→SETTLE and is stable through RESULT.

## Configuration
- SAR_SEQ_AVG_EN defined:
  - Each grant performs 2^AVG_LOG2 consecutive conversions; each repeats SETTLE→CONVERT, with mux_sel unchanged.
  - Accumulator is NSTEP+AVG_LOG2 bits; res_code = acc >> AVG_LOG2 (truncation).
  - Any error aborts the remaining samples: res_err=1, res_code=0.
- SAR_SEQ_AVG_EN undefined: one conversion per grant. AVG_LOG2 is ignored and the accumulator is NSTEP bits.

## Test plan
- Single request: req=4'b0100, sar_code=10'h155 at eoc toggle → sar_soc toggles 9 cycles after grant, mux_sel=2, res_code=10'h155, res_ch=2, res_err=0, ack=4'b0100 on handshake.
- Round robin: req=4'b1111 held → served order 0,1,2,3,0. Then req=4'b1001 after serving 3 → 0 next.
- Timeout: no sar_eoc edge → res_valid exactly TIMEOUT+1 cycles after soc toggle, res_err=1, res_code=0.
- Simultaneous sar_err and sar_eoc toggles → res_err=1, res_code=0. Backpressure: res_ready low 20 cycles → outputs stable, single ack.
- Reset mid-CONVERT: rstb low 1 cycle → all outputs at reset values next cycle. A late eoc toggle then yields no result.
- With SAR_SEQ_AVG_EN, AVG_LOG2=2, codes 100,101,102,104 → 4 soc toggles, res_code=101.

Source files
------------

// File: rtl/sar_sequencer.sv
// Round-robin scheduler sharing one SAR ADC between NCH requesters.
// Optional multi-sample averaging per grant is enabled by defining SAR_SEQ_AVG_EN.
module sar_sequencer #(
    parameter int NCH      = 4,
    parameter int CH_W     = 2,
    parameter int NSTEP    = 10,
    parameter int SETTLE   = 8,
    parameter int TIMEOUT  = 64,
    parameter int AVG_LOG2 = 2
) (
    input  logic             f100m_clk,
    input  logic             rstb,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   ack,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_ch,
    output logic [NSTEP-1:0] res_code,
    output logic             res_err,
    output logic             busy,
    output logic [CH_W-1:0]  mux_sel,
    output logic             sar_soc,
    input  logic             sar_eoc,
    input  logic             sar_err,
    input  logic [NSTEP-1:0] sar_code
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONVERT, S_RESULT} state_t;

    localparam int CNT_W = 10;
`ifdef SAR_SEQ_AVG_EN
    localparam int AVG_SH = AVG_LOG2;
`else
    localparam int AVG_SH = 0 * AVG_LOG2;
`endif
    localparam int ACC_W = NSTEP + AVG_SH;

    state_t           state;
    logic [CH_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             eoc_q, err_q;
    logic             eoc_edge, err_edge;
    logic             last_smp;
    logic [NCH-1:0]   rot;
    logic             gnt_vld;
    logic [CH_W-1:0]  gnt_ch;

    assign eoc_edge = sar_eoc ^ eoc_q;
    assign err_edge = sar_err ^ err_q;
    assign acc_sum  = acc + ACC_W'(sar_code);

    // Rotate requests so bit 0 is the pointer; the lowest set bit is the winner.
    always_comb begin
        logic [CH_W:0] sum;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        sum     = '0;
        rot     = NCH'({req, req} >> ptr);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + (CH_W+1)'(i);
            end
        end
        if (int'(sum) >= NCH)
            sum = sum - (CH_W+1)'(NCH);
        gnt_ch = sum[CH_W-1:0];
    end

    always_comb begin
        ack = '0;
        if (res_valid && res_ready)
            ack[res_ch] = 1'b1;
    end

`ifdef SAR_SEQ_AVG_EN
    localparam int NSAMP = 1 << AVG_LOG2;
    logic [AVG_LOG2:0] smp;

    always_ff @(posedge f100m_clk) begin
        if (!rstb)
            smp <= '0;
        else if (state == S_IDLE)
            smp <= '0;
        else if (state == S_CONVERT && eoc_edge && !err_edge)
            smp <= smp + 1'b1;
    end
    assign last_smp = (int'(smp) == NSAMP - 1);
`else
    assign last_smp = 1'b1;
`endif

    always_ff @(posedge f100m_clk) begin
        if (!rstb) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            acc       <= '0;
            mux_sel   <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_code  <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
            sar_soc   <= 1'b0;
            eoc_q     <= sar_eoc;
            err_q     <= sar_err;
        end else begin
            eoc_q <= sar_eoc;
            err_q <= sar_err;
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        mux_sel <= gnt_ch;
                        cnt     <= CNT_W'(SETTLE);
                        acc     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        sar_soc <= ~sar_soc;
                        cnt     <= CNT_W'(TIMEOUT);
                        state   <= S_CONVERT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CONVERT: begin
                    // An error on any sample aborts the whole grant.
                    if (err_edge || (!eoc_edge && cnt == '0)) begin
                        res_valid <= 1'b1;
                        res_ch    <= mux_sel;
                        res_code  <= '0;
                        res_err   <= 1'b1;
                        state     <= S_RESULT;
                    end else if (eoc_edge) begin
                        if (last_smp) begin
                            res_valid <= 1'b1;
                            res_ch    <= mux_sel;
                            res_code  <= NSTEP'(acc_sum >> AVG_SH);
                            res_err   <= 1'b0;
                            state     <= S_RESULT;
                        end else begin
                            acc   <= acc_sum;
                            cnt   <= CNT_W'(SETTLE);
                            state <= S_SETTLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= (res_ch == CH_W'(NCH - 1)) ? '0 : res_ch + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_sequencer.sv
// Randomized bench for sar_sequencer: SAR responder driven from the bench, results
// checked against a round-robin / latency / averaging reference model.
module tb_sar_sequencer;

    localparam int NCH      = 4;
    localparam int CH_W     = 2;
    localparam int NSTEP    = 10;
    localparam int SETTLE   = 8;
    localparam int TIMEOUT  = 64;
    localparam int AVG_LOG2 = 2;
`ifdef SAR_SEQ_AVG_EN
    localparam int NS = 1 << AVG_LOG2;
    localparam int SH = AVG_LOG2;
`else
    localparam int NS = 1;
    localparam int SH = 0;
`endif

    localparam int M_EOC = 0, M_ERR = 1, M_BOTH = 2, M_TMO = 3;

    logic             f100m_clk;
    logic             rstb;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   ack;
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_ch;
    logic [NSTEP-1:0] res_code;
    logic             res_err;
    logic             busy;
    logic [CH_W-1:0]  mux_sel;
    logic             sar_soc;
    logic             sar_eoc;
    logic             sar_err;
    logic [NSTEP-1:0] sar_code;

    sar_sequencer #(
        .NCH(NCH), .CH_W(CH_W), .NSTEP(NSTEP), .SETTLE(SETTLE),
        .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .f100m_clk(f100m_clk), .rstb(rstb), .req(req), .ack(ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_code(res_code), .res_err(res_err), .busy(busy), .mux_sel(mux_sel),
        .sar_soc(sar_soc), .sar_eoc(sar_eoc), .sar_err(sar_err), .sar_code(sar_code)
    );

    initial f100m_clk = 1'b0;
    always #5 f100m_clk = ~f100m_clk;

    int               n_chk  = 0;
    int               n_fail = 0;
    logic             soc_m  = 1'b0;
    int               ptr_m  = 0;
    logic [NSTEP-1:0] smp_code [0:7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bail();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] r, input int p);
        for (int k = 0; k < NCH; k++)
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        return -1;
    endfunction

    task automatic wait_busy();
        bit ok = 0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge f100m_clk);
            if (busy === 1'b1) ok = 1;
        end
        if (!ok) begin check("wait_grant", 32'(ok), 1); bail(); end
    endtask

    task automatic wait_soc(output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge f100m_clk);
            n++;
            if (sar_soc !== soc_m) ok = 1;
        end
        if (!ok) begin check("wait_soc", 32'(ok), 1); bail(); end
        soc_m = ~soc_m;
    endtask

    task automatic wait_valid(input int bound, output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge f100m_clk);
            n++;
            if (res_valid === 1'b1) ok = 1;
        end
        if (!ok) begin check("wait_valid", 32'(ok), 1); bail(); end
    endtask

    task automatic run_txn(input int mode, input int d, input int rdy, output int ch);
        int            n;
        logic [NSTEP+3:0] sum;
        logic [NSTEP-1:0] exp_code;
        logic          exp_err;
        bit            stable;
        ch  = rr_pick(req, ptr_m);
        sum = '0;
        wait_busy();
        for (int k = 0; k < NS; k++) begin
            wait_soc(n);
            if (k == 0) check("settle_lat", 32'(n), SETTLE + 1);
            check("mux_sel", 32'(mux_sel), 32'(ch));
            if (mode == M_TMO) begin
                wait_valid(200, n);
                check("timeout_lat", 32'(n), TIMEOUT + 1);
                break;
            end
            repeat (d) @(negedge f100m_clk);
            if (mode != M_ERR) begin
                sar_code = smp_code[k];
                sar_eoc  = ~sar_eoc;
            end
            if (mode != M_EOC) sar_err = ~sar_err;
            sum = sum + (NSTEP+4)'(smp_code[k]);
            if (mode != M_EOC || k == NS - 1) begin
                wait_valid(5, n);
                check("eoc_lat", 32'(n), 1);
                break;
            end
        end
        exp_err  = (mode != M_EOC);
        exp_code = exp_err ? '0 : NSTEP'(sum >> SH);
        stable = 1;
        for (int r = 0; r < rdy; r++) begin
            @(negedge f100m_clk);
            if (res_valid !== 1'b1 || res_ch !== CH_W'(ch) || res_code !== exp_code ||
                res_err !== exp_err || ack !== '0 || mux_sel !== CH_W'(ch))
                stable = 0;
        end
        check("hold", 32'(stable), 1);
        check("res_ch", 32'(res_ch), 32'(ch));
        check("res_code", 32'(res_code), 32'(exp_code));
        check("res_err", 32'(res_err), 32'(exp_err));
        res_ready = 1'b1;
        #1;
        check("ack", 32'(ack), 32'(1) << ch);
        @(negedge f100m_clk);
        res_ready = 1'b0;
        #1;
        check("ack_clr", 32'(ack), 0);
        check("idle", {30'b0, res_valid, busy}, 0);
        ptr_m = (ch + 1) % NCH;
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, {ack, res_valid, res_ch, res_code, res_err, busy, mux_sel, sar_soc}, 0);
    endtask

    initial begin
        int ch;
        int mode;
        bit quiet;
        rstb = 1'b0; req = '0; res_ready = 1'b0;
        sar_eoc = 1'b0; sar_err = 1'b0; sar_code = '0;
        for (int i = 0; i < 8; i++) smp_code[i] = '0;
        repeat (3) @(negedge f100m_clk);
        check_reset_outs("reset_outs");
        rstb = 1'b1;

        // Round robin with all requests held, then a sparse pattern.
        req = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NS; k++) smp_code[k] = NSTEP'($urandom);
            run_txn(M_EOC, t, 0, ch);
        end
        req = 4'b1001;
        run_txn(M_EOC, 1, 2, ch);
        run_txn(M_EOC, 0, 0, ch);

        // Single request, long backpressure.
        req = 4'b0100;
        for (int k = 0; k < NS; k++) smp_code[k] = 10'h155;
        run_txn(M_EOC, 3, 20, ch);

        req = 4'b0001;
        run_txn(M_TMO, 0, 1, ch);
        req = 4'b1000;
        smp_code[0] = 10'h2aa;
        run_txn(M_BOTH, 5, 3, ch);
        req = 4'b0010;
        run_txn(M_ERR, 2, 0, ch);

`ifdef SAR_SEQ_AVG_EN
        req = 4'b0010;
        smp_code[0] = 10'd100; smp_code[1] = 10'd101;
        smp_code[2] = 10'd102; smp_code[3] = 10'd104;
        run_txn(M_EOC, 2, 0, ch);
`endif

        req = NCH'($urandom_range(1, (1 << NCH) - 1));
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < NS; k++) smp_code[k] = NSTEP'($urandom);
            mode = $urandom_range(0, 9);
            mode = (mode < 6) ? M_EOC : (mode == 6) ? M_ERR : (mode == 7) ? M_BOTH :
                   (mode == 8) ? M_TMO : M_EOC;
            run_txn(mode, $urandom_range(0, 40), $urandom_range(0, 20), ch);
            req = (req & ~(NCH'(1) << ch)) | NCH'($urandom_range(0, (1 << NCH) - 1));
            if (req == '0) req = NCH'(1) << $urandom_range(0, NCH - 1);
        end

        // Reset in the middle of a conversion; a late eoc must not produce a result.
        @(negedge f100m_clk);
        req = '0;
        repeat (3) @(negedge f100m_clk);
        req = 4'b0010;
        wait_busy();
        begin
            int n;
            wait_soc(n);
        end
        repeat (3) @(negedge f100m_clk);
        rstb = 1'b0;
        req  = '0;
        @(negedge f100m_clk);
        rstb = 1'b1;
        #1;
        check_reset_outs("midreset_outs");
        soc_m = 1'b0;
        ptr_m = 0;
        sar_code = 10'h3ff;
        sar_eoc  = ~sar_eoc;
        quiet = 1;
        repeat (10) begin
            @(negedge f100m_clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        check("late_eoc", 32'(quiet), 1);

        req = 4'b0110;
        smp_code[0] = 10'h0f0;
        for (int k = 1; k < NS; k++) smp_code[k] = 10'h0f0;
        run_txn(M_EOC, 4, 1, ch);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
